// File: rtl/wbs_ctrl_regs.sv
// WISHBONE slave control/status register block: IDENT, VERSION, SCRATCH, CTRL,
// PULSE, STATUS and a free-running COUNTER, one-cycle registered termination.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for cyc&stb; access is decoded and committed here
// ST_RESP | one-cycle termination (ack or err), strobe ignored
module wbs_ctrl_regs #(
   parameter logic [31:0] IDENT   = 32'h5355_5246,
   parameter logic [31:0] VERSION = 32'h0000_0001
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [15:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic [31:0] ctrl_o,
   output logic [7:0]  pulse_o,
   input  logic [31:0] status_i
);

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   localparam logic [13:0] W_IDENT   = 14'd0;
   localparam logic [13:0] W_VERSION = 14'd1;
   localparam logic [13:0] W_SCRATCH = 14'd2;
   localparam logic [13:0] W_CTRL    = 14'd3;
   localparam logic [13:0] W_PULSE   = 14'd4;
   localparam logic [13:0] W_STATUS  = 14'd5;
   localparam logic [13:0] W_COUNTER = 14'd6;

   state_t      state_q, state_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] dat_q, dat_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [7:0]  pulse_q, pulse_d;

   logic [13:0] word_adr;
   logic        mapped;
   logic        unused_adr_lsb;

   assign word_adr       = wb_adr_i[15:2];
   assign mapped         = (word_adr <= W_COUNTER);
   assign unused_adr_lsb = &{1'b0, wb_adr_i[1:0]};

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   always_comb begin
      state_d   = state_q;
      scratch_d = scratch_q;
      ctrl_d    = ctrl_q;
      cnt_d     = cnt_q + 32'd1;
      dat_d     = 32'd0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      pulse_d   = 8'd0;
      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = ST_RESP;
               ack_d   = mapped;
               err_d   = !mapped;
               if (wb_we_i) begin
                  case (word_adr)
                     W_SCRATCH: scratch_d = merge_lanes(scratch_q, wb_dat_i, wb_sel_i);
                     W_CTRL:    ctrl_d    = merge_lanes(ctrl_q, wb_dat_i, wb_sel_i);
                     W_PULSE:   if (wb_sel_i[0]) pulse_d = wb_dat_i[7:0];
                     // clear overrides this edge's increment
                     W_COUNTER: if (|wb_sel_i) cnt_d = 32'd0;
                     default:   ;
                  endcase
               end else begin
                  case (word_adr)
                     W_IDENT:   dat_d = IDENT;
                     W_VERSION: dat_d = VERSION;
                     W_SCRATCH: dat_d = scratch_q;
                     W_CTRL:    dat_d = ctrl_q;
                     W_STATUS:  dat_d = status_i;
                     W_COUNTER: dat_d = cnt_q;
                     default:   dat_d = 32'd0;
                  endcase
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         scratch_q <= 32'd0;
         ctrl_q    <= 32'd0;
         cnt_q     <= 32'd0;
         dat_q     <= 32'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         pulse_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         pulse_q   <= pulse_d;
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;
   assign ctrl_o   = ctrl_q;
   assign pulse_o  = pulse_q;

endmodule

// File: tb/tb_wbs_ctrl_regs.sv
// Directed bench for wbs_ctrl_regs: a register-map model checks every cycle,
// literal expectations pin the key scenarios.
module tb_wbs_ctrl_regs;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [15:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [3:0]  wb_sel_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;
   logic [31:0] ctrl_o;
   logic [7:0]  pulse_o;
   logic [31:0] status_i = '0;

   int checks = 0;
   int errors = 0;

   wbs_ctrl_regs dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
      .wb_rty_o(wb_rty_o), .ctrl_o(ctrl_o), .pulse_o(pulse_o),
      .status_i(status_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- register-map model ----------------
   logic [31:0] m_scratch, m_ctrl, m_cnt;
   logic        m_busy;
   logic        pre_tgl = 1'b0, pre_seen = 1'b0;
   logic [31:0] pre_val = '0;

   initial begin
      logic [31:0] e_dat;
      logic        e_ack, e_err;
      logic [7:0]  e_pls;
      int          idx;
      m_scratch = 0; m_ctrl = 0; m_cnt = 0; m_busy = 0;
      forever begin
         @(posedge clk_i);
         e_dat = 0; e_ack = 0; e_err = 0; e_pls = 0;
         if (!rst_n_i) begin
            m_scratch = 0; m_ctrl = 0; m_cnt = 0; m_busy = 0;
         end else begin
            if (pre_tgl != pre_seen) begin
               m_cnt = pre_val;
               pre_seen = pre_tgl;
            end
            if (!m_busy && wb_cyc_i && wb_stb_i) begin
               idx    = int'(wb_adr_i >> 2);
               e_ack  = (idx < 7);
               e_err  = !e_ack;
               m_busy = 1;
               if (wb_we_i) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wb_sel_i[b] && idx == 2) m_scratch[8*b +: 8] = wb_dat_i[8*b +: 8];
                     if (wb_sel_i[b] && idx == 3) m_ctrl[8*b +: 8]    = wb_dat_i[8*b +: 8];
                  end
                  if (idx == 4 && wb_sel_i[0]) e_pls = wb_dat_i[7:0];
               end else begin
                  case (idx)
                     0: e_dat = 32'h5355_5246;
                     1: e_dat = 32'h0000_0001;
                     2: e_dat = m_scratch;
                     3: e_dat = m_ctrl;
                     5: e_dat = status_i;
                     6: e_dat = m_cnt;
                     default: e_dat = 0;
                  endcase
               end
               if (wb_we_i && idx == 6 && wb_sel_i != 0) m_cnt = 0;
               else m_cnt = m_cnt + 1;
            end else begin
               m_busy = 0;
               m_cnt  = m_cnt + 1;
            end
         end
         #1;
         if (rst_n_i) begin
            chk("m_ack", {31'd0, wb_ack_o}, {31'd0, e_ack});
            chk("m_err", {31'd0, wb_err_o}, {31'd0, e_err});
            chk("m_rty", {31'd0, wb_rty_o}, 32'd0);
            chk("m_dat", wb_dat_o, e_dat);
            chk("m_pulse", {24'd0, pulse_o}, {24'd0, e_pls});
            chk("m_ctrl", ctrl_o, m_ctrl);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Call at a negedge; returns at the negedge inside the termination cycle.
   task automatic access(input logic we, input logic [15:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd,
                         output logic ack, output logic err, output logic [7:0] pls,
                         output int lat);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = d; wb_sel_i = sel;
      rd = 0; ack = 0; err = 0; pls = 0; lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) begin
            rd = wb_dat_o; ack = wb_ack_o; err = wb_err_o; pls = pulse_o; lat = i;
            break;
         end
      end
      if (lat == 0) chk("access_timeout", 32'd0, 32'd1);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        ack, err;
      logic [7:0]  pls;
      int          lat;
      logic [5:0]  pat;

      repeat (3) @(negedge clk_i);
      chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_ctrl", ctrl_o, 32'd0);
      chk("rst_pulse", {24'd0, pulse_o}, 32'd0);
      rst_n_i = 1;

      access(0, 16'h0000, 0, 4'hF, rd, ack, err, pls, lat);
      chk("ident", rd, 32'h5355_5246);
      chk("ident_lat", lat, 1);
      chk("ident_ack", {30'd0, ack, err}, 32'd2);
      @(negedge clk_i);
      access(0, 16'h0004, 0, 4'hF, rd, ack, err, pls, lat);
      chk("version", rd, 32'h0000_0001);
      chk("version_lat", lat, 1);

      access(1, 16'h000C, 32'hAABB_CCDD, 4'b0101, rd, ack, err, pls, lat);
      chk("ctrl_o", ctrl_o, 32'h00BB_00DD);
      chk("ctrl_wr_term", {30'd0, ack, err}, 32'd2);
      access(0, 16'h000C, 0, 4'hF, rd, ack, err, pls, lat);
      chk("ctrl_rd", rd, 32'h00BB_00DD);
      access(1, 16'h000C, 32'h1111_1111, 4'b0000, rd, ack, err, pls, lat);
      chk("ctrl_sel0_ack", {31'd0, ack}, 32'd1);
      chk("ctrl_sel0", ctrl_o, 32'h00BB_00DD);

      access(1, 16'h0008, 32'hDEAD_BEEF, 4'b1100, rd, ack, err, pls, lat);
      access(0, 16'h0008, 0, 4'hF, rd, ack, err, pls, lat);
      chk("scratch_rd", rd, 32'hDEAD_0000);

      access(1, 16'h0010, 32'h0000_0081, 4'b0001, rd, ack, err, pls, lat);
      chk("pulse_81", {24'd0, pls}, 32'h81);
      @(negedge clk_i);
      chk("pulse_gone", {24'd0, pulse_o}, 32'd0);
      access(1, 16'h0010, 32'h0000_0081, 4'b1110, rd, ack, err, pls, lat);
      chk("pulse_sel_hi", {24'd0, pls}, 32'd0);
      access(0, 16'h0010, 0, 4'hF, rd, ack, err, pls, lat);
      chk("pulse_rd0", rd, 32'd0);

      access(0, 16'h0020, 0, 4'hF, rd, ack, err, pls, lat);
      chk("unmap_rd_term", {30'd0, ack, err}, 32'd1);
      chk("unmap_rd_dat", rd, 32'd0);
      access(1, 16'h0020, 32'hFFFF_FFFF, 4'hF, rd, ack, err, pls, lat);
      chk("unmap_wr_term", {30'd0, ack, err}, 32'd1);
      access(0, 16'h0008, 0, 4'hF, rd, ack, err, pls, lat);
      chk("scratch_kept", rd, 32'hDEAD_0000);

      access(1, 16'h0000, 32'h0, 4'hF, rd, ack, err, pls, lat);
      chk("ro_wr_ack", {30'd0, ack, err}, 32'd2);
      access(0, 16'h0007, 0, 4'hF, rd, ack, err, pls, lat);
      chk("adr_lsb_ignored", rd, 32'h0000_0001);

      status_i = 32'hCAFE_0123;
      access(0, 16'h0014, 0, 4'hF, rd, ack, err, pls, lat);
      status_i = 32'h0BAD_F00D;
      chk("status", rd, 32'hCAFE_0123);

      @(negedge clk_i);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 16'h0000;
      pat = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         pat[k] = wb_ack_o;
      end
      wb_cyc_i = 0; wb_stb_i = 0;
      chk("hold_pattern", {26'd0, pat}, 32'h15);

      @(negedge clk_i);
      access(1, 16'h0018, 32'h0, 4'b0010, rd, ack, err, pls, lat);
      access(0, 16'h0018, 0, 4'hF, rd, ack, err, pls, lat);
      chk("cnt_small", {31'd0, rd < 32'd4}, 32'd1);

      @(negedge clk_i);
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      pre_val = 32'hFFFF_FFFE;
      pre_tgl = ~pre_tgl;
      @(negedge clk_i);
      access(0, 16'h0018, 0, 4'hF, rd, ack, err, pls, lat);
      chk("cnt_max", rd, 32'hFFFF_FFFF);
      access(0, 16'h0018, 0, 4'hF, rd, ack, err, pls, lat);
      chk("cnt_wrap", rd, 32'h0000_0001);

      // reset arrives during the termination cycle of a SCRATCH write
      @(negedge clk_i);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 16'h0008;
      wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
      @(negedge clk_i);
      chk("pre_rst_ack", {31'd0, wb_ack_o}, 32'd1);
      rst_n_i = 0;
      #1;
      chk("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
      chk("rst_mid_err", {31'd0, wb_err_o}, 32'd0);
      chk("rst_mid_ctrl", ctrl_o, 32'd0);
      chk("rst_mid_pulse", {24'd0, pulse_o}, 32'd0);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1;
      access(0, 16'h0008, 0, 4'hF, rd, ack, err, pls, lat);
      chk("post_rst_lat", lat, 1);
      chk("post_rst_scratch", rd, 32'd0);
      chk("post_rst_ack", {30'd0, ack, err}, 32'd2);

      repeat (2) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
